// File: rtl/jtcps1_gfx_pkg.sv
// Shared definitions for the CPS1 graphics ROM arbiter: widths, requester
// indices, FSM encoding and the round-robin pick helper.
package jtcps1_gfx_pkg;

    localparam int NREQ = 4;
    localparam int KEYW = 21;
    localparam int DW   = 32;
    localparam int AW   = 20;
    localparam int SAW  = 22;

    localparam logic [1:0] SCR1 = 2'd0;
    localparam logic [1:0] SCR2 = 2'd1;
    localparam logic [1:0] SCR3 = 2'd2;
    localparam logic [1:0] OBJ  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Scan starts just after the last grant so every requester gets a turn.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] pend, input logic [1:0] last);
        pick_t      p;
        logic [1:0] c;
        p = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = last + 2'(k);
            if (!p.found && pend[c]) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/jtcps1_gfx_slot.sv
// One requester's single-entry tag/data cache with its registered ok flag.
module jtcps1_gfx_slot
    import jtcps1_gfx_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cs,
    input  logic [KEYW-1:0] key,
    input  logic            fill,
    input  logic [KEYW-1:0] fill_key,
    input  logic [DW-1:0]   fill_data,
    output logic            hit,
    output logic            ok,
    output logic [DW-1:0]   data
);

    logic            valid_reg;
    logic [KEYW-1:0] tag_reg;
    logic [DW-1:0]   data_reg;
    logic            ok_reg;

    // A hit needs the live key; a fill tagged with a stale key never matches.
    assign hit  = cs & valid_reg & (tag_reg == key);
    assign ok   = ok_reg;
    assign data = data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
            ok_reg    <= 1'b0;
        end else begin
            ok_reg <= hit;
            if (fill) begin
                valid_reg <= 1'b1;
                tag_reg   <= fill_key;
                data_reg  <= fill_data;
            end
        end
    end

endmodule

// File: rtl/jtcps1_gfx_arb.sv
// Round-robin arbiter sharing one 32-bit graphics SDRAM port between the
// three scroll engines and the object engine, each fronted by a 1-entry cache.
module jtcps1_gfx_arb
    import jtcps1_gfx_pkg::*;
#(
    parameter logic [21:0] OFF0 = 22'h000000,
    parameter logic [21:0] OFF1 = 22'h000000,
    parameter logic [21:0] OFF2 = 22'h000000,
    parameter logic [21:0] OFF3 = 22'h000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_half,
    input  logic [NREQ-1:0]      req_cs,
    output logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ok,
    output logic [SAW-1:0]       sdram_addr,
    output logic                 sdram_req,
    input  logic                 sdram_ack,
    input  logic                 sdram_dok,
    input  logic [DW-1:0]        sdram_data
);

    function automatic logic [SAW-1:0] off_sel(input logic [1:0] idx);
        case (idx)
            SCR1:    off_sel = OFF0;
            SCR2:    off_sel = OFF1;
            SCR3:    off_sel = OFF2;
            default: off_sel = OFF3;
        endcase
    endfunction

    state_t          state_reg, state_next;
    logic [1:0]      rr_reg, rr_next;
    logic [1:0]      grant_reg, grant_next;
    logic [KEYW-1:0] fkey_reg, fkey_next;
    logic            sreq_reg, sreq_next;
    logic [SAW-1:0]  saddr_reg, saddr_next;

    logic [KEYW-1:0] key [NREQ];
    logic [NREQ-1:0] hit;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] fill_en;
    pick_t           pick;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            logic inflight;
            assign key[gi]     = {req_addr[AW*gi +: AW], req_half[gi]};
            assign inflight    = (state_reg != ST_IDLE) && (grant_reg == 2'(gi));
            assign pending[gi] = req_cs[gi] & ~hit[gi] & ~inflight;

            jtcps1_gfx_slot u_slot (
                .clk       (clk),
                .rst       (rst),
                .cs        (req_cs[gi]),
                .key       (key[gi]),
                .fill      (fill_en[gi]),
                .fill_key  (fkey_reg),
                .fill_data (sdram_data),
                .hit       (hit[gi]),
                .ok        (req_ok[gi]),
                .data      (req_data[DW*gi +: DW])
            );
        end
    endgenerate

    assign pick       = rr_pick(pending, rr_reg);
    assign sdram_req  = sreq_reg;
    assign sdram_addr = saddr_reg;

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        grant_next = grant_reg;
        fkey_next  = fkey_reg;
        sreq_next  = sreq_reg;
        saddr_next = saddr_reg;
        fill_en    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (pick.found) begin
                    grant_next = pick.idx;
                    rr_next    = pick.idx;
                    fkey_next  = key[pick.idx];
                    saddr_next = off_sel(pick.idx) + {1'b0, key[pick.idx]};
                    sreq_next  = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    sreq_next = 1'b0;
                    // A controller that returns data with the ack skips WAIT.
                    if (sdram_dok) begin
                        fill_en[grant_reg] = 1'b1;
                        state_next         = ST_FILL;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sdram_dok) begin
                    fill_en[grant_reg] = 1'b1;
                    state_next         = ST_FILL;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rr_reg    <= 2'd3;
            grant_reg <= 2'd0;
            fkey_reg  <= '0;
            sreq_reg  <= 1'b0;
            saddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            grant_reg <= grant_next;
            fkey_reg  <= fkey_next;
            sreq_reg  <= sreq_next;
            saddr_reg <= saddr_next;
        end
    end

endmodule

// File: tb/tb_jtcps1_gfx_arb.sv
// Directed bench for jtcps1_gfx_arb: misses, hits, rotation, stale fills,
// combined ack/dok and asynchronous reset during a fetch.
module tb_jtcps1_gfx_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [79:0]  req_addr = '0;
    logic [3:0]   req_half = '0;
    logic [3:0]   req_cs = '0;
    logic [127:0] req_data;
    logic [3:0]   req_ok;
    logic [21:0]  sdram_addr;
    logic         sdram_req;
    logic         sdram_ack = 1'b0;
    logic         sdram_dok = 1'b0;
    logic [31:0]  sdram_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtcps1_gfx_arb #(
        .OFF0 (22'h000000),
        .OFF1 (22'h010000),
        .OFF2 (22'h020000),
        .OFF3 (22'h100000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_addr   (req_addr),
        .req_half   (req_half),
        .req_cs     (req_cs),
        .req_data   (req_data),
        .req_ok     (req_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_addr(input int i, input logic [19:0] a);
        req_addr[20*i +: 20] = a;
    endtask

    // Wait for a request, check its address, ack, then return data one cycle later.
    task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [31:0] d);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_req"}, 128'(sdram_req), 128'(1'b1));
        chk({tag, "_addr"}, 128'(sdram_addr), 128'(exp_addr));
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        tick;
        sdram_dok  = 1'b1;
        sdram_data = d;
        tick;
        sdram_dok = 1'b0;
    endtask

    initial begin
        int bad;
        tick;
        chk("rst_req", 128'(sdram_req), 128'(0));
        chk("rst_addr", 128'(sdram_addr), 128'(0));
        chk("rst_ok", 128'(req_ok), 128'(0));
        chk("rst_data", req_data, 128'(0));
        rst = 1'b0;
        tick;

        // Single miss on the object port
        set_addr(3, 20'h01234);
        req_half[3] = 1'b1;
        req_cs      = 4'b1000;
        tick;
        chk("miss_req", 128'(sdram_req), 128'(1));
        chk("miss_addr", 128'(sdram_addr), 128'(22'h102469));
        tick;
        chk("miss_req_held", 128'(sdram_req), 128'(1));
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        chk("miss_req_drop", 128'(sdram_req), 128'(0));
        tick;
        sdram_dok  = 1'b1;
        sdram_data = 32'hDEADBEEF;
        tick;
        sdram_dok = 1'b0;
        chk("miss_ok_fill", 128'(req_ok[3]), 128'(0));
        tick;
        chk("miss_ok", 128'(req_ok[3]), 128'(1));
        chk("miss_data", 128'(req_data[127:96]), 128'(32'hDEADBEEF));

        // Hit hold for 50 cycles
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (sdram_req || !req_ok[3]) bad++;
        end
        chk("hit_hold_bad", 128'(bad), 128'(0));
        req_half[3] = 1'b0;
        tick;
        chk("rekey_ok", 128'(req_ok[3]), 128'(0));
        serve("rekey", 22'h102468, 32'h11112222);
        tick;
        tick;
        chk("rekey_ok2", 128'(req_ok[3]), 128'(1));
        req_cs = 4'b0000;

        // Contention from reset
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_addr(0, 20'h00010);
        set_addr(1, 20'h00020);
        set_addr(2, 20'h00030);
        set_addr(3, 20'h00040);
        req_half = 4'b0000;
        req_cs   = 4'b1111;
        serve("rr0", 22'h000020, 32'hA0A0A0A0);
        serve("rr1", 22'h010040, 32'hB1B1B1B1);
        serve("rr2", 22'h020060, 32'hC2C2C2C2);
        serve("rr3", 22'h100080, 32'hD3D3D3D3);
        tick;
        tick;
        chk("rr_ok", 128'(req_ok), 128'(4'hF));
        chk("rr_data", req_data, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0});

        // Re-miss on 1 and 3 with rr=3
        set_addr(1, 20'h00021);
        set_addr(3, 20'h00041);
        tick;
        chk("remiss_ok", 128'(req_ok), 128'(4'b0101));
        serve("re1", 22'h010042, 32'h01010101);
        serve("re3", 22'h100082, 32'h03030303);
        tick;
        tick;
        chk("remiss_ok2", 128'(req_ok), 128'(4'hF));

        // Key change while the fetch is in flight
        req_cs = 4'b0001;
        set_addr(0, 20'h00100);
        bad = 0;
        while (!sdram_req && bad < 20) begin
            tick;
            bad++;
        end
        chk("kc_addr", 128'(sdram_addr), 128'(22'h000200));
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        set_addr(0, 20'h00101);
        tick;
        sdram_dok  = 1'b1;
        sdram_data = 32'hAAAA5555;
        tick;
        sdram_dok = 1'b0;
        tick;
        chk("kc_stale_ok", 128'(req_ok[0]), 128'(0));
        chk("kc_stale_req", 128'(sdram_req), 128'(0));
        chk("kc_stale_data", 128'(req_data[31:0]), 128'(32'hAAAA5555));
        tick;
        chk("kc_rereq", 128'(sdram_req), 128'(1));
        serve("kc_new", 22'h000202, 32'h12345678);
        tick;
        tick;
        chk("kc_ok", 128'(req_ok[0]), 128'(1));
        chk("kc_data", 128'(req_data[31:0]), 128'(32'h12345678));

        // Same-cycle ack and dok
        set_addr(0, 20'h00102);
        bad = 0;
        while (!sdram_req && bad < 20) begin
            tick;
            bad++;
        end
        chk("ad_addr", 128'(sdram_addr), 128'(22'h000204));
        sdram_ack  = 1'b1;
        sdram_dok  = 1'b1;
        sdram_data = 32'h600DF00D;
        tick;
        sdram_ack = 1'b0;
        sdram_dok = 1'b0;
        chk("ad_req_drop", 128'(sdram_req), 128'(0));
        chk("ad_ok_fill", 128'(req_ok[0]), 128'(0));
        tick;
        chk("ad_ok", 128'(req_ok[0]), 128'(1));
        chk("ad_data", 128'(req_data[31:0]), 128'(32'h600DF00D));

        // Asynchronous reset during WAIT
        set_addr(0, 20'h00103);
        req_cs = 4'b0011;
        tick;
        chk("ar_req", 128'(sdram_req), 128'(1));
        chk("ar_ok_pre", 128'(req_ok), 128'(4'b0010));
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_req_now", 128'(sdram_req), 128'(0));
        chk("ar_ok_now", 128'(req_ok), 128'(0));
        chk("ar_data_now", req_data, 128'(0));
        tick;
        rst = 1'b0;
        serve("ar0", 22'h000206, 32'h0BAD0000);
        serve("ar1", 22'h010042, 32'h0BAD0001);
        tick;
        tick;
        chk("ar_ok_post", 128'(req_ok), 128'(4'b0011));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtcps1_gfx_arb.md
Name: jtcps1_gfx_arb

Overview:
- Round-robin arbiter that shares the single 32-bit graphics SDRAM port between the three scroll tile engines and the object draw engine (jtcps1_obj rom_* interface).
- Each requester gets a one-entry tag/data cache, so a requester holding a constant address sees rom_ok stay high without re-fetching.
- Sits between the video layer engines and the SDRAM controller.

Parameters:
- OFF0, 22'h000000, SDRAM word offset added to requester 0 (scroll1) addresses
- OFF1, 22'h000000, offset for requester 1 (scroll2)
- OFF2, 22'h000000, offset for requester 2 (scroll3)
- OFF3, 22'h000000, offset for requester 3 (obj)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_addr  in  80  four 20-bit ROM addresses, requester i at [20i+19:20i]
- req_half  in  4  half select per requester; forms key {addr,half} (21 bits)
- req_cs  in  4  request valid per requester; held with its address until ok
- req_data  out  128  32-bit cached data per requester, [32i+31:32i]
- req_ok  out  4  data valid for the current key of requester i
- sdram_addr  out  22  word address to the SDRAM controller
- sdram_req  out  1  fetch request; held until sdram_ack
- sdram_ack  in  1  one-cycle pulse: request accepted
- sdram_dok  in  1  one-cycle pulse: sdram_data valid
- sdram_data  in  32  fetched data

Behaviour:
- Reset (asynchronous): req_ok=0, req_data=0, sdram_req=0, sdram_addr=0, all valid bits=0, rr pointer=3 (so requester 0 wins first), state IDLE.
- Per-requester cache: valid bit, 21-bit tag, 32-bit data.
- Hit: hit_i = req_cs[i] & valid_i & (tag_i=={req_addr_i,req_half[i]}).
- req_ok[i] is a register equal to hit_i from the previous cycle, giving 1-cycle hit latency.
- req_ok[i] must be 0 in the cycle after the key changes or cs drops.
- Miss: pending_i = req_cs[i] & ~hit_i & ~(in-flight for i).
- FSM IDLE:
  - If any pending_i, grant g = first pending index after rr pointer, modulo 4.
  - Latch key_g, set sdram_addr = OFFg + zero-extend(key), sdram_req=1, rr<=g, go to REQ.
- FSM REQ: hold sdram_req and sdram_addr. On sdram_ack: sdram_req<=0, go to WAIT.
- FSM WAIT: on sdram_dok, write tag_g<=latched key, data_g<=sdram_data, valid_g<=1, go to FILL.
- FSM FILL: one dead cycle for the cache to settle, then IDLE.
- Minimum miss-to-ok latency is 4 cycles plus SDRAM latency (IDLE→REQ, ack, dok, FILL/ok register).
- sdram_ack and sdram_dok in the same cycle: treated as ack then immediate fill; REQ goes directly to FILL.
- Simultaneous pending requests: rotation order only. No fixed priority, so no starvation; worst-case wait is 3 transactions.
- Key changes while its fetch is in flight:
  - The fill still lands with the old latched key.
  - The new key misses and is re-requested after FILL.
  - ok is never asserted for stale data.
- req_cs drops mid-flight: the transaction completes and the cache is filled; ok stays 0 while cs=0.
- A requester with a valid hit is never granted.
- Offset addition wraps modulo 2^22.
- sdram_dok pulses in IDLE or REQ are ignored.
- Reset mid-transaction: everything returns to reset values immediately. sdram_req drops asynchronously; the SDRAM controller discards the stale response.

Decomposition:
- Shared package jtcps1_gfx_pkg:
  - state encoding IDLE/REQ/WAIT/FILL
  - NREQ=4, KEYW=21, DW=32
  - requester index constants SCR1=0, SCR2=1, SCR3=2, OBJ=3
- One natural sub-module: jtcps1_gfx_slot. It holds one requester's tag/data/valid and the hit/ok register, and is instantiated 4 times.
- Arbitration FSM and round-robin logic stay in the top.

Test Plan:
- Single miss: req_cs=4'b1000, obj addr 20'h01234, half=1, OFF3=22'h100000 → sdram_addr=22'h102469, sdram_req until ack. Data 32'hDEADBEEF on dok → req_ok[3]=1 and req_data[127:96]=32'hDEADBEEF two cycles later.
- Hit hold: keep the same key for 50 cycles → no further sdram_req, req_ok[3] stays 1. Change half to 0 → req_ok[3]=0 next cycle, new fetch at 22'h102468.
- Contention: all four cs raised with distinct misses from reset → grants in order 0,1,2,3. Re-miss on 1 and 3 while rr=3 → order 1 then 3.
- Key change in flight: requester 0 changes addr during WAIT → the fill does not raise ok; a second sdram_req for the new key follows FILL.
- Same-cycle ack+dok: the controller pulses both together → the cache fills, and ok arrives the same number of cycles after dok as in the normal case.
- Reset mid-WAIT: assert rst asynchronously → sdram_req, req_ok and valid are all 0 at once. After release, the first pending miss is re-requested with requester 0 first.
